// File: rtl/tt_sweep_pkg.sv
// tt_sweep_pkg
// Shared types and constants for the truth-table sweep controller.
//   sweep_state_t : controller FSM states
//   N_IN_DEF      : default number of function inputs
//   SETTLE_DEF    : default settle cycles per vector
//   tt_w(n)       : truth-table width (2^n) for an n-input function
package tt_sweep_pkg;

    localparam int N_IN_DEF   = 4;
    localparam int SETTLE_DEF = 2;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } sweep_state_t;

    function automatic int tt_w(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// tt_settle_timer
// Counts the cycles a vector has been held on the function under test.
// Ports:
//   clk     in  : system clock, rising edge
//   rst     in  : synchronous active-high reset
//   clear   in  : restart the count at zero (new vector)
//   en      in  : count this cycle
//   expired out : count has reached SETTLE_CYC-1
module tt_settle_timer
    import tt_sweep_pkg::*;
#(
    parameter int SETTLE_CYC = SETTLE_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(SETTLE_CYC - 1);

    logic [CW-1:0] cnt;

    // Saturates at the terminal count so a stalled enable never wraps.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == LAST_CNT);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl
// Drives every input vector 0..LAST_VEC onto an external combinational
// function, waits SETTLE_CYC cycles per vector, captures F into a truth
// table and flags the first vector whose F differs from the expected table.
// Ports:
//   clk       in  : system clock, rising edge
//   rst       in  : synchronous active-high reset
//   start     in  : begin a sweep (accepted only when idle)
//   abort     in  : stop a sweep in progress, keep partial results
//   expect_tt in  : expected F per vector, latched on accepted start
//   f_in      in  : F from the function under test
//   abcd      out : vector applied to the function (MSB = A)
//   busy      out : sweep in progress
//   done      out : one-cycle pulse when the sweep completes
//   result_tt out : captured F, bit k = F for vector k
//   err       out : at least one mismatch this sweep
//   err_idx   out : vector index of the first mismatch
module tt_sweep_ctrl
    import tt_sweep_pkg::*;
#(
    parameter int N_IN       = N_IN_DEF,
    parameter int LAST_VEC   = 15,
    parameter int SETTLE_CYC = SETTLE_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [tt_w(N_IN)-1:0] expect_tt,
    input  logic                  f_in,
    output logic [N_IN-1:0]       abcd,
    output logic                  busy,
    output logic                  done,
    output logic [tt_w(N_IN)-1:0] result_tt,
    output logic                  err,
    output logic [N_IN-1:0]       err_idx
);

    localparam int TT_W = tt_w(N_IN);
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(LAST_VEC);

    sweep_state_t    state_q, state_d;
    logic [N_IN-1:0] vec_q;
    logic [TT_W-1:0] exp_q;
    logic [TT_W-1:0] result_q;
    logic            err_q;
    logic [N_IN-1:0] err_idx_q;
    logic            busy_q;
    logic            done_q;

    logic accept, sample, advance, finish, halt;
    logic timer_expired;
    logic mismatch;

    tt_settle_timer #(
        .SETTLE_CYC(SETTLE_CYC)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept || advance),
        .en      (state_q == SETTLE),
        .expired (timer_expired)
    );

    assign mismatch = (f_in != exp_q[vec_q]);

    // Next-state and per-cycle action strobes. abort is checked first in
    // every active state so it overrides sampling and completion.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        sample  = 1'b0;
        advance = 1'b0;
        finish  = 1'b0;
        halt    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (abort) begin
                    halt    = 1'b1;
                    state_d = IDLE;
                end else if (timer_expired) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    halt    = 1'b1;
                    state_d = IDLE;
                end else begin
                    sample = 1'b1;
                    if (vec_q == LAST_IDX) begin
                        finish  = 1'b1;
                        state_d = DONE;
                    end else begin
                        advance = 1'b1;
                        state_d = SETTLE;
                    end
                end
            end
            DONE: begin
                halt    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. The vector counter doubles as the abcd
    // output register, so abcd changes on the edge that enters SETTLE and
    // keeps the last vector while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            vec_q     <= '0;
            exp_q     <= '0;
            result_q  <= '0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= finish;
            if (accept) begin
                exp_q     <= expect_tt;
                result_q  <= '0;
                err_q     <= 1'b0;
                err_idx_q <= '0;
                vec_q     <= '0;
                busy_q    <= 1'b1;
            end
            if (sample) begin
                result_q[vec_q] <= f_in;
                if (mismatch && !err_q) begin
                    err_q     <= 1'b1;
                    err_idx_q <= vec_q;
                end
            end
            if (advance) begin
                vec_q <= vec_q + 1'b1;
            end
            if (halt) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign abcd      = vec_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign result_tt = result_q;
    assign err       = err_q;
    assign err_idx   = err_idx_q;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// tb_tt_sweep_ctrl
// Two controller instances (default parameters, and LAST_VEC=12 with
// SETTLE_CYC=4) each driving a truth-table function model. Expected
// results come from a sweep model built on the truth-table rules.
module tb_tt_sweep_ctrl;

    localparam int L1 = 15;
    localparam int S1 = 2;
    localparam int L2 = 12;
    localparam int S2 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start1, abort1, start2, abort2;
    logic [15:0] exp1, exp2, func1, func2;
    logic [3:0]  abcd1, abcd2, err_idx1, err_idx2;
    logic        busy1, busy2, done1, done2, err1, err2;
    logic [15:0] result1, result2;
    logic        f1, f2;

    int sel;
    int n_compared;
    int n_mismatched;

    logic [3:0]  cur_abcd, cur_err_idx;
    logic        cur_busy, cur_done, cur_err;
    logic [15:0] cur_result;

    assign f1 = func1[abcd1];
    assign f2 = func2[abcd2];

    assign cur_abcd    = (sel == 1) ? abcd2    : abcd1;
    assign cur_err_idx = (sel == 1) ? err_idx2 : err_idx1;
    assign cur_busy    = (sel == 1) ? busy2    : busy1;
    assign cur_done    = (sel == 1) ? done2    : done1;
    assign cur_err     = (sel == 1) ? err2     : err1;
    assign cur_result  = (sel == 1) ? result2  : result1;

    tt_sweep_ctrl #(.N_IN(4), .LAST_VEC(L1), .SETTLE_CYC(S1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1),
        .expect_tt(exp1), .f_in(f1), .abcd(abcd1), .busy(busy1),
        .done(done1), .result_tt(result1), .err(err1), .err_idx(err_idx1)
    );

    tt_sweep_ctrl #(.N_IN(4), .LAST_VEC(L2), .SETTLE_CYC(S2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2),
        .expect_tt(exp2), .f_in(f2), .abcd(abcd2), .busy(busy2),
        .done(done2), .result_tt(result2), .err(err2), .err_idx(err_idx2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Sweep reference: the first n_captured vectors are read from the
    // function table; the first one whose value differs from the expected
    // table is the reported error index.
    task automatic modelSweep(input logic [15:0] func, input logic [15:0] expv,
                              input int n_captured, output logic [15:0] res,
                              output logic m_err, output logic [3:0] m_idx);
        res   = 16'h0;
        m_err = 1'b0;
        m_idx = 4'h0;
        for (int v = 0; v < n_captured; v++) begin
            res[v] = func[v];
            if (func[v] != expv[v] && !m_err) begin
                m_err = 1'b1;
                m_idx = 4'(v);
            end
        end
    endtask

    task automatic applyStimulus(input int which, input logic [15:0] func,
                                 input logic [15:0] expv, input bit with_abort);
        sel = which;
        if (which == 1) begin
            func2  = func;
            exp2   = expv;
            start2 = 1'b1;
            abort2 = with_abort;
        end else begin
            func1  = func;
            exp1   = expv;
            start1 = 1'b1;
            abort1 = with_abort;
        end
        tick();
        start1 = 1'b0;
        start2 = 1'b0;
        abort1 = 1'b0;
        abort2 = 1'b0;
    endtask

    task automatic runSweep(input int which, input logic [15:0] func,
                            input logic [15:0] expv, input bit with_abort);
        int          last, settle, cyc, bad;
        logic [15:0] m_res;
        logic        m_err;
        logic [3:0]  m_idx;
        last   = (which == 1) ? L2 : L1;
        settle = (which == 1) ? S2 : S1;
        applyStimulus(which, func, expv, with_abort);
        cyc = 1;
        bad = 0;
        checkOutput("busy_after_start", 32'(cur_busy), 1);
        while (cur_done !== 1'b1 && cyc < 200) begin
            if (int'(cur_abcd) != (cyc - 1) / (settle + 1)) bad++;
            tick();
            cyc++;
        end
        checkOutput("done_cycle", cyc, 1 + (last + 1) * (settle + 1));
        checkOutput("abcd_order", bad, 0);
        checkOutput("abcd_final", 32'(cur_abcd), last);
        modelSweep(func, expv, last + 1, m_res, m_err, m_idx);
        checkOutput("result_tt", 32'(cur_result), 32'(m_res));
        checkOutput("err", 32'(cur_err), 32'(m_err));
        checkOutput("err_idx", 32'(cur_err_idx), 32'(m_idx));
        tick();
        checkOutput("done_one_cycle", 32'(cur_done), 0);
        checkOutput("busy_cleared", 32'(cur_busy), 0);
    endtask

    initial begin
        logic [15:0] fn, ev, m_res;
        logic        m_err;
        logic [3:0]  m_idx;
        int          pulses;

        n_compared   = 0;
        n_mismatched = 0;
        sel    = 0;
        rst    = 1'b1;
        start1 = 1'b0; abort1 = 1'b0; start2 = 1'b0; abort2 = 1'b0;
        exp1   = 16'h0; exp2 = 16'h0; func1 = 16'h0; func2 = 16'h0;
        $display("[TB] reset");
        tick();
        tick();
        rst = 1'b0;
        checkOutput("rst_abcd", 32'(abcd1), 0);
        checkOutput("rst_busy", 32'(busy1), 0);
        checkOutput("rst_done", 32'(done1), 0);
        checkOutput("rst_result", 32'(result1), 0);
        checkOutput("rst_err", 32'(err1), 0);
        checkOutput("rst_err_idx", 32'(err_idx1), 0);

        $display("[TB] AND-of-4 sweep");
        runSweep(0, 16'h8000, 16'h8000, 1'b0);
        checkOutput("and_result_const", 32'(result1), 32'h8000);

        $display("[TB] XOR sweep with bit 5 flipped in expectation");
        runSweep(0, 16'h6996, 16'h69B6, 1'b0);
        checkOutput("xor_err_idx_const", 32'(err_idx1), 5);

        $display("[TB] OR sweep, LAST_VEC=12, SETTLE_CYC=4");
        runSweep(1, 16'hFFFE, 16'h1FFE, 1'b0);
        checkOutput("or_result_const", 32'(result2), 32'h1FFE);

        $display("[TB] abort at E+10");
        fn = 16'($urandom);
        ev = fn ^ 16'h0002;
        applyStimulus(0, fn, ev, 1'b0);
        repeat (8) tick();
        checkOutput("abort_pre_abcd", 32'(abcd1), 2);
        tick();
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        checkOutput("abort_busy", 32'(busy1), 0);
        checkOutput("abort_done", 32'(done1), 0);
        modelSweep(fn, ev, (10 - 1) / (S1 + 1), m_res, m_err, m_idx);
        checkOutput("abort_result", 32'(result1), 32'(m_res));
        checkOutput("abort_err", 32'(err1), 32'(m_err));
        checkOutput("abort_err_idx", 32'(err_idx1), 32'(m_idx));
        pulses = 0;
        repeat (60) begin
            tick();
            if (done1 === 1'b1 || busy1 === 1'b1) pulses++;
        end
        checkOutput("abort_quiet", pulses, 0);
        checkOutput("abort_abcd_held", 32'(abcd1), 3);
        runSweep(0, 16'($urandom), 16'($urandom), 1'b0);

        $display("[TB] start while busy, then reset at E+20");
        fn = 16'($urandom);
        applyStimulus(0, fn, fn, 1'b0);
        repeat (4) tick();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (13) tick();
        checkOutput("ignored_start_abcd", 32'(abcd1), 6);
        checkOutput("ignored_start_busy", 32'(busy1), 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrst_abcd", 32'(abcd1), 0);
        checkOutput("midrst_busy", 32'(busy1), 0);
        checkOutput("midrst_done", 32'(done1), 0);
        checkOutput("midrst_result", 32'(result1), 0);
        checkOutput("midrst_err", 32'(err1), 0);
        checkOutput("midrst_err_idx", 32'(err_idx1), 0);

        $display("[TB] start and abort together in IDLE");
        fn = 16'($urandom);
        runSweep(0, fn, fn, 1'b1);

        $display("[TB] mismatches at vectors 3 and 9");
        fn = 16'($urandom);
        runSweep(0, fn, fn ^ 16'h0208, 1'b0);
        checkOutput("two_mm_idx_const", 32'(err_idx1), 3);

        $display("[TB] randomized sweeps");
        for (int i = 0; i < 4; i++) begin
            fn = 16'($urandom);
            ev = fn;
            if ($urandom_range(0, 1) == 1) ev = ev ^ (16'h1 << $urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) ev = ev ^ (16'h1 << $urandom_range(0, 15));
            runSweep(0, fn, ev, 1'b0);
            fn = 16'($urandom);
            ev = fn ^ (16'h1 << $urandom_range(13, 15));
            if ($urandom_range(0, 1) == 1) ev = ev ^ (16'h1 << $urandom_range(0, 12));
            runSweep(1, fn, ev, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
